// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: instruction ROM read port, decode handshake and redirect.
// master = fetch unit side, slave = ROM/decoder/branch side.
interface fetch_unit_if #(
    parameter int ADDR_W  = 15,
    parameter int INSTR_W = 16
);
    logic               rom_req;
    logic [ADDR_W-1:0]  rom_addr;
    logic               rom_ack;
    logic [INSTR_W-1:0] rom_data;
    logic               instr_valid;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_pc;
    logic               instr_ready;
    logic               jump;
    logic [ADDR_W-1:0]  jump_addr;

    modport master (
        output rom_req, rom_addr,
        input  rom_ack, rom_data,
        output instr_valid, instr, instr_pc,
        input  instr_ready, jump, jump_addr
    );

    modport slave (
        input  rom_req, rom_addr,
        output rom_ack, rom_data,
        input  instr_valid, instr, instr_pc,
        output instr_ready, jump, jump_addr
    );
endinterface

// File: rtl/fetch_unit.sv
// Hack-style instruction fetch front end: owns the PC, reads the ROM over req/ack,
// hands words to decode over valid/ready. Optional stall counter: FETCH_STALL_CNT_EN.
module fetch_unit #(
    parameter int                 ADDR_W       = 15,
    parameter int                 INSTR_W      = 16,
    parameter logic [ADDR_W-1:0]  RESET_VECTOR = '0
) (
    input  logic         clk,
    input  logic         reset,
`ifdef FETCH_STALL_CNT_EN
    output logic [15:0]  stall_cnt,
`endif
    fetch_unit_if.master bus
);

    typedef enum logic [1:0] {
        START   = 2'd0,
        FETCH   = 2'd1,
        DISCARD = 2'd2,
        HOLD    = 2'd3
    } state_t;

    state_t             state, state_n;
    logic [ADDR_W-1:0]  pc, pc_n;
    logic               req_n;
    logic [ADDR_W-1:0]  addr_n;
    logic               valid_n;
    logic [INSTR_W-1:0] instr_n;
    logic [ADDR_W-1:0]  ipc_n;

    // State, PC and all outputs are registered together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= START;
            pc              <= RESET_VECTOR;
            bus.rom_req     <= 1'b0;
            bus.rom_addr    <= '0;
            bus.instr_valid <= 1'b0;
            bus.instr       <= '0;
            bus.instr_pc    <= '0;
        end else begin
            state           <= state_n;
            pc              <= pc_n;
            bus.rom_req     <= req_n;
            bus.rom_addr    <= addr_n;
            bus.instr_valid <= valid_n;
            bus.instr       <= instr_n;
            bus.instr_pc    <= ipc_n;
        end
    end

    // Next-state sequencing; a jump overrides everything except reset.
    always_comb begin
        state_n = state;
        pc_n    = pc;
        req_n   = bus.rom_req;
        addr_n  = bus.rom_addr;
        valid_n = bus.instr_valid;
        instr_n = bus.instr;
        ipc_n   = bus.instr_pc;
        unique case (state)
            START: begin
                pc_n    = bus.jump ? bus.jump_addr : pc;
                state_n = FETCH;
                req_n   = 1'b1;
                addr_n  = pc_n;
            end
            FETCH: begin
                if (bus.jump) begin
                    pc_n = bus.jump_addr;
                    if (bus.rom_ack) begin
                        addr_n = bus.jump_addr;
                    end else begin
                        // Outstanding read must complete; its data is dropped.
                        state_n = DISCARD;
                    end
                end else if (bus.rom_ack) begin
                    instr_n = bus.rom_data;
                    ipc_n   = bus.rom_addr;
                    valid_n = 1'b1;
                    req_n   = 1'b0;
                    pc_n    = bus.rom_addr + ADDR_W'(1);
                    state_n = HOLD;
                end
            end
            DISCARD: begin
                pc_n = bus.jump ? bus.jump_addr : pc;
                if (bus.rom_ack) begin
                    addr_n  = pc_n;
                    state_n = FETCH;
                end
            end
            HOLD: begin
                if (bus.jump) begin
                    pc_n    = bus.jump_addr;
                    valid_n = 1'b0;
                    req_n   = 1'b1;
                    addr_n  = bus.jump_addr;
                    state_n = FETCH;
                end else if (bus.instr_ready) begin
                    valid_n = 1'b0;
                    req_n   = 1'b1;
                    addr_n  = pc;
                    state_n = FETCH;
                end
            end
            default: begin
                state_n = START;
            end
        endcase
    end

`ifdef FETCH_STALL_CNT_EN
    // Saturating count of cycles lost waiting on the ROM or the decoder.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (((bus.instr_valid && !bus.instr_ready) ||
                      (bus.rom_req && !bus.rom_ack)) &&
                     (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule
